// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions for the EX and MEM stages.
//   - data path width and opcode field position
//   - load/store opcodes and the branch-class mask
//   - mem_state_t, the MEM-stage access FSM state type
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    localparam logic [5:0] OP_LW = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b100001;

    // Branches are opcode[5:2] == 4'b1101. MEM treats them as non-memory ops.
    localparam logic [5:0] BR_CLASS_MASK = 6'b111100;
    localparam logic [5:0] BR_CLASS_VAL  = 6'b110100;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port of the MEM stage.
//   master: drives dmem_req/we/addr/wdata and samples dmem_ready/rdata (MEM stage)
//   slave : the data memory
interface mem_stage_if #(
    parameter int AW = 32
);
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_ready;
    logic [31:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_req_fsm.sv
// Data-memory access sequencer of the MEM stage.
// Owns the access state, dmem_req and the address/wdata/we holding registers,
// so the request stays constant for the whole access.
//   start        : launch an access (only honoured in IDLE)
//   start_*      : address, write enable and write data to hold
//   dmem_ready   : memory handshake
//   busy         : state == ACCESS (drives the EX stall)
//   done         : access completes at the coming edge
//   req/we/addr/wdata : request presented to memory
//
// state  | meaning
// IDLE   | no access outstanding, ready to accept from EX
// ACCESS | request held on the port until dmem_ready
module mem_req_fsm
    import mips_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          start_we,
    input  logic [31:0]   start_wdata,
    input  logic          dmem_ready,
    output logic          busy,
    output logic          done,
    output logic          req,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [31:0]   wdata
);

    mem_state_t    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCESS;
                    addr_d  = start_addr;
                    we_d    = start_we;
                    wdata_d = start_wdata;
                end
            end
            ACCESS: begin
                if (dmem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // req is decoded straight from the state flop so a reset drops it at once.
    assign busy  = (state_q == ACCESS);
    assign req   = busy;
    assign done  = busy && dmem_ready;
    assign we    = we_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access pipeline stage (between EX and WB).
// Decodes LW/SW, runs word accesses through mem_req_fsm, stalls EX while an
// access is outstanding and hands every instruction to WB as a one-cycle
// valid_mem pulse with its WB register set.
//   clk, rst        : clock, async active-high reset
//   valid_ex, ALU_out, B_ex, IR_ex, NPC_ex : instruction from EX
//   stall_o         : EX must hold
//   dmem            : data-memory port (master side)
//   valid_mem, LMD_mem, ALU_out_mem, IR_mem, NPC_mem, misalign_mem : to WB
// Build option MEM_STAGE_ALIGN_CHECK_EN: a misaligned LW/SW skips memory and
// retires at once with misalign_mem=1. Without it the low address bits are
// dropped and misalign_mem is tied 0.
module mem_stage
    import mips_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_ex,
    input  logic [31:0] ALU_out,
    input  logic [31:0] B_ex,
    input  logic [31:0] IR_ex,
    input  logic [31:0] NPC_ex,
    output logic        stall_o,
    mem_stage_if.master dmem,
    output logic        valid_mem,
    output logic [31:0] LMD_mem,
    output logic [31:0] ALU_out_mem,
    output logic [31:0] IR_mem,
    output logic [31:0] NPC_mem,
    output logic        misalign_mem
);

    logic [5:0] opcode;
    logic       mem_op, misaligned, accept, start, retire_ex;
    logic       busy, done;

    logic [31:0] h_alu_q, h_alu_d, h_ir_q, h_ir_d, h_npc_q, h_npc_d;
    logic        valid_q, valid_d;
    logic [31:0] lmd_q, lmd_d, alu_q, alu_d, ir_q, ir_d, npc_q, npc_d;

    assign opcode = IR_ex[OPC_HI:OPC_LO];
    assign mem_op = is_mem_op(opcode);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    assign misaligned = mem_op && (ALU_out[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // EX is only accepted while no access is outstanding.
    assign accept    = valid_ex && !busy;
    assign start     = accept && mem_op && !misaligned;
    assign retire_ex = accept && !start;

    mem_req_fsm #(.AW(AW)) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  ({ALU_out[AW-1:2], 2'b00}),
        .start_we    (opcode == OP_SW),
        .start_wdata (B_ex),
        .dmem_ready  (dmem.dmem_ready),
        .busy        (busy),
        .done        (done),
        .req         (dmem.dmem_req),
        .we          (dmem.dmem_we),
        .addr        (dmem.dmem_addr),
        .wdata       (dmem.dmem_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_alu_q <= '0;
            h_ir_q  <= '0;
            h_npc_q <= '0;
            valid_q <= 1'b0;
            lmd_q   <= '0;
            alu_q   <= '0;
            ir_q    <= '0;
            npc_q   <= '0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            h_alu_q <= h_alu_d;
            h_ir_q  <= h_ir_d;
            h_npc_q <= h_npc_d;
            valid_q <= valid_d;
            lmd_q   <= lmd_d;
            alu_q   <= alu_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    always_comb begin
        h_alu_d = h_alu_q;
        h_ir_d  = h_ir_q;
        h_npc_d = h_npc_q;
        valid_d = 1'b0;
        lmd_d   = lmd_q;
        alu_d   = alu_q;
        ir_d    = ir_q;
        npc_d   = npc_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        if (start) begin
            h_alu_d = ALU_out;
            h_ir_d  = IR_ex;
            h_npc_d = NPC_ex;
        end
        // start and done are exclusive: start needs !busy, done needs busy.
        if (retire_ex) begin
            valid_d = 1'b1;
            lmd_d   = '0;
            alu_d   = ALU_out;
            ir_d    = IR_ex;
            npc_d   = NPC_ex;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            mis_d   = misaligned;
`endif
        end else if (done) begin
            valid_d = 1'b1;
            lmd_d   = (h_ir_q[OPC_HI:OPC_LO] == OP_LW) ? dmem.dmem_rdata : '0;
            alu_d   = h_alu_q;
            ir_d    = h_ir_q;
            npc_d   = h_npc_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            mis_d   = 1'b0;
`endif
        end
    end

    assign stall_o     = busy;
    assign valid_mem   = valid_q;
    assign LMD_mem     = lmd_q;
    assign ALU_out_mem = alu_q;
    assign IR_mem      = ir_q;
    assign NPC_mem     = npc_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misalign_mem = mis_q;
`else
    assign misalign_mem = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. A retire queue holds what WB must see
// and in which cycle; an access queue holds what the memory port must show
// and how long the memory waits before answering.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ex;
    logic [31:0] ALU_out, B_ex, IR_ex, NPC_ex;
    logic        stall_o, valid_mem, misalign_mem;
    logic [31:0] LMD_mem, ALU_out_mem, IR_mem, NPC_mem;

    always #5 clk = ~clk;

    mem_stage_if #(.AW(32)) dmem ();

    mem_stage #(.AW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_ex     (valid_ex),
        .ALU_out      (ALU_out),
        .B_ex         (B_ex),
        .IR_ex        (IR_ex),
        .NPC_ex       (NPC_ex),
        .stall_o      (stall_o),
        .dmem         (dmem.master),
        .valid_mem    (valid_mem),
        .LMD_mem      (LMD_mem),
        .ALU_out_mem  (ALU_out_mem),
        .IR_mem       (IR_mem),
        .NPC_mem      (NPC_mem),
        .misalign_mem (misalign_mem)
    );

    typedef struct {
        logic [31:0] alu, ir, npc, lmd;
        logic        mis;
        int          exp_cyc;   // cycle valid_mem is due; -1 until memory answers
    } ret_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata, addr, wdata;
        logic        we;
    } acc_t;

    ret_t rq[$];
    acc_t mq[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int req_rises = 0;
    int rise_cyc[$];
    int stall_cnt = 0;
    int req_cnt = 0;
    logic prev_req = 1'b0;
    logic idle_noise = 1'b0;
    logic [31:0] last_addr = 32'h0;

    localparam logic [5:0] LW = 6'b100000;
    localparam logic [5:0] SW = 6'b100001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder and request checker.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            dmem.dmem_ready = 1'b0;
            dmem.dmem_rdata = 32'h0;
            req_cnt = 0;
        end else if (dmem.dmem_req) begin
            if (!prev_req) begin
                req_rises++;
                rise_cyc.push_back(cyc);
            end
            last_addr = dmem.dmem_addr;
            if (mq.size() == 0) begin
                chk("unexpected_req", 32'(dmem.dmem_req), 32'd0);
            end else begin
                chk("dmem_addr", dmem.dmem_addr, mq[0].addr);
                chk("dmem_we", 32'(dmem.dmem_we), 32'(mq[0].we));
                if (mq[0].we) chk("dmem_wdata", dmem.dmem_wdata, mq[0].wdata);
                if (req_cnt == mq[0].delay) begin
                    dmem.dmem_ready = 1'b1;
                    dmem.dmem_rdata = mq[0].rdata;
                    void'(mq.pop_front());
                    if (rq.size() > 0) rq[0].exp_cyc = cyc + 1;
                    req_cnt = 0;
                end else begin
                    dmem.dmem_ready = 1'b0;
                    dmem.dmem_rdata = 32'hBAD0_0000 + 32'(req_cnt);
                    req_cnt++;
                end
            end
        end else begin
            req_cnt = 0;
            dmem.dmem_ready = idle_noise;
            dmem.dmem_rdata = $urandom;
        end
        prev_req = dmem.dmem_req;
    end

    // WB compare process.
    initial forever begin
        logic exp_valid;
        ret_t e;
        @(negedge clk);
        if (rst) begin
            chk("rst_valid_mem", 32'(valid_mem), 32'd0);
            chk("rst_dmem_req", 32'(dmem.dmem_req), 32'd0);
            chk("rst_stall", 32'(stall_o), 32'd0);
        end else begin
            if (stall_o) stall_cnt++;
            exp_valid = (rq.size() > 0) && (rq[0].exp_cyc == cyc);
            chk("valid_mem", 32'(valid_mem), 32'(exp_valid));
            if (valid_mem && exp_valid) begin
                e = rq.pop_front();
                chk("ALU_out_mem", ALU_out_mem, e.alu);
                chk("IR_mem", IR_mem, e.ir);
                chk("NPC_mem", NPC_mem, e.npc);
                chk("LMD_mem", LMD_mem, e.lmd);
                chk("misalign_mem", 32'(misalign_mem), 32'(e.mis));
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] b,
                         input logic [31:0] npc, input int delay, input logic [31:0] rdata);
        ret_t e;
        acc_t a;
        logic mem, mis;
        int guard;
        @(negedge clk);
        guard = 0;
        while (stall_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (stall_o) chk("issue_stall_timeout", 32'(stall_o), 32'd0);
        valid_ex = 1'b1;
        ALU_out  = alu;
        B_ex     = b;
        IR_ex    = {op, alu[25:0] ^ 26'h1ABCDEF};
        NPC_ex   = npc;
        mem = (op == LW) || (op == SW);
        mis = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        if (mem && alu[1:0] != 2'b00) begin
            mis = 1'b1;
            mem = 1'b0;
        end
`endif
        e.alu = alu;
        e.ir  = IR_ex;
        e.npc = npc;
        e.lmd = (mem && op == LW) ? rdata : 32'h0;
        e.mis = mis;
        a.delay = delay;
        a.rdata = rdata;
        a.addr  = alu & 32'hFFFF_FFFC;
        a.we    = (op == SW);
        a.wdata = b;
        @(posedge clk);
        #1;
        e.exp_cyc = mem ? -1 : cyc;
        rq.push_back(e);
        if (mem) mq.push_back(a);
        valid_ex = 1'b0;
        ALU_out  = $urandom;
        B_ex     = $urandom;
        IR_ex    = {LW, 26'(($urandom))};
        NPC_ex   = $urandom;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((rq.size() != 0 || mq.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, cap, cv, s0;
        rst = 1'b1;
        valid_ex = 1'b0;
        ALU_out = 32'h0; B_ex = 32'h0; IR_ex = 32'h0; NPC_ex = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_LMD", LMD_mem, 32'h0);
        chk("rst_ALU_out_mem", ALU_out_mem, 32'h0);
        chk("rst_IR_mem", IR_mem, 32'h0);
        chk("rst_NPC_mem", NPC_mem, 32'h0);
        chk("rst_misalign", 32'(misalign_mem), 32'd0);
        chk("rst_dmem_addr", dmem.dmem_addr, 32'h0);
        chk("rst_dmem_we", 32'(dmem.dmem_we), 32'd0);
        chk("rst_dmem_wdata", dmem.dmem_wdata, 32'h0);
        rst = 1'b0;

        // ALU op retires in the cycle right after capture, never stalls.
        stall_cnt = 0;
        issue(6'b000000, 32'h15, 32'h0, 32'h104, 0, 32'h0);
        @(negedge clk);
        chk("alu_valid", 32'(valid_mem), 32'd1);
        chk("alu_result", ALU_out_mem, 32'h15);
        chk("alu_lmd", LMD_mem, 32'h0);

        // Idle with dmem_ready toggling: nothing may happen.
        idle_noise = 1'b1;
        repeat (4) @(negedge clk);
        chk("alu_no_stall", 32'(stall_cnt), 32'd0);

        // SW answered 3 cycles after the request rises: 4 stall cycles.
        stall_cnt = 0;
        r0 = req_rises;
        issue(SW, 32'h40, 32'hDEADBEEF, 32'h108, 3, 32'h0);
        drain();
        chk("sw_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("sw_req_pulses", 32'(req_rises - r0), 32'd1);

        // LW zero-wait: the edge after capture completes it.
        issue(LW, 32'h44, 32'h0, 32'h10C, 0, 32'h12345678);
        cap = cyc;
        cv = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_mem) begin
                cv = cyc;
                break;
            end
        end
        chk("lw_latency", 32'(cv - cap), 32'd1);
        chk("lw_data", LMD_mem, 32'h12345678);

        // LW then SW back-to-back, zero-wait: one idle req cycle between.
        s0 = rise_cyc.size();
        issue(LW, 32'h80, 32'h0, 32'h110, 0, 32'hCAFEF00D);
        issue(SW, 32'h84, 32'h0BADF00D, 32'h114, 0, 32'h0);
        drain();
        chk("b2b_req_count", 32'(rise_cyc.size() - s0), 32'd2);
        if (rise_cyc.size() - s0 == 2)
            chk("b2b_req_gap", 32'(rise_cyc[s0+1] - rise_cyc[s0]), 32'd2);

        // Non-memory opcodes back-to-back, including a branch and opcode[5]=1.
        issue(6'b110100, 32'h200, 32'h1, 32'h118, 0, 32'h0);
        issue(6'b001000, 32'h7, 32'h2, 32'h11C, 0, 32'h0);
        issue(6'b100010, 32'h303, 32'h3, 32'h120, 0, 32'h0);
        drain();

        // Misaligned LW.
        r0 = req_rises;
        issue(LW, 32'h42, 32'h0, 32'h124, 1, 32'h5555AAAA);
        drain();
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        chk("misalign_no_req", 32'(req_rises - r0), 32'd0);
`else
        chk("misalign_req", 32'(req_rises - r0), 32'd1);
        chk("misalign_addr", last_addr, 32'h40);
`endif

        // Reset in the middle of a long access.
        idle_noise = 1'b0;
        issue(LW, 32'h100, 32'h0, 32'h128, 50, 32'h11111111);
        repeat (3) @(negedge clk);
        chk("mid_access_req", 32'(dmem.dmem_req), 32'd1);
        #2;
        rst = 1'b1;
        rq.delete();
        mq.delete();
        #1;
        chk("async_req_drop", 32'(dmem.dmem_req), 32'd0);
        chk("async_stall_drop", 32'(stall_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(LW, 32'h104, 32'h0, 32'h12C, 1, 32'hA5A55A5A);
        drain();
        issue(SW, 32'h108, 32'h600DCAFE, 32'h130, 2, 32'h0);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
